// File: rtl/aes_subbytes_engine_if.sv
// Bundle for the AddRoundKey+SubBytes engine: input word/key, S-box lookup port, result port.
// master = surrounding system (producer, S-box memory, consumer); slave = the engine.
interface aes_subbytes_engine_if #(
  parameter int LANES = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [127:0]         in_word;
  logic [127:0]         in_key;
  logic                 sbox_req;
  logic [8*LANES-1:0]   sbox_addr;
  logic                 sbox_ack;
  logic [8*LANES-1:0]   sbox_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [127:0]         out_cipher;
  logic                 out_err;

  modport master (
    output in_valid, in_word, in_key, sbox_ack, sbox_data, out_ready,
    input  in_ready, sbox_req, sbox_addr, out_valid, out_cipher, out_err
  );

  modport slave (
    input  in_valid, in_word, in_key, sbox_ack, sbox_data, out_ready,
    output in_ready, sbox_req, sbox_addr, out_valid, out_cipher, out_err
  );
endinterface

// File: rtl/aes_subbytes_engine.sv
// AES AddRoundKey + SubBytes engine; bytes go through an external S-box LANES at a time.
// Define AES_SHIFTROWS_EN to present the ShiftRows permutation of the state on out_cipher.
module aes_subbytes_engine #(
  parameter int LANES   = 4,
  parameter int TIMEOUT = 64
) (
  input logic                 clk,
  input logic                 rst,
  aes_subbytes_engine_if.slave bus
);
  localparam int         BEATS = 16 / LANES;
  localparam logic [3:0] LAST  = 4'(BEATS - 1);
  localparam logic [7:0] TMAX  = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t             state, nxt;
  logic [127:0]       st, cipher;
  logic [3:0]         beat;
  logic [7:0]         timer;
  logic [8*LANES-1:0] addr;
  logic               err, rdy, req, vld;

  // Gather the LANES state bytes of beat b; lane j = byte b*LANES+j.
  function automatic logic [8*LANES-1:0] lanes_at(input logic [127:0] w, input logic [3:0] b);
    logic [8*LANES-1:0] r;
    r = '0;
    for (int j = 0; j < LANES; j++) r[8*j +: 8] = w[8*(15 - (int'(b)*LANES + j)) +: 8];
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    rdy = 1'b0;
    req = 1'b0;
    vld = 1'b0;
    case (state)
      IDLE: begin
        rdy = 1'b1;
        if (bus.in_valid) nxt = REQ;
      end
      REQ: begin
        req = 1'b1;
        if (bus.sbox_ack) begin
          if (beat == LAST) nxt = DONE;
        end else if (timer == TMAX) begin
          nxt = DONE;
        end
      end
      DONE: begin
        vld = 1'b1;
        if (bus.out_ready) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st    <= '0;
      beat  <= '0;
      timer <= '0;
      addr  <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          st    <= bus.in_word ^ bus.in_key;
          beat  <= '0;
          timer <= '0;
          addr  <= lanes_at(bus.in_word ^ bus.in_key, 4'd0);
          err   <= 1'b0;
        end
        REQ: begin
          if (bus.sbox_ack) begin
            for (int j = 0; j < LANES; j++)
              st[8*(15 - (int'(beat)*LANES + j)) +: 8] <= bus.sbox_data[8*j +: 8];
            timer <= '0;
            if (beat == LAST) begin
              addr <= '0;
            end else begin
              // Next beat's bytes are untouched by this write, so the old st is correct.
              beat <= beat + 4'd1;
              addr <= lanes_at(st, beat + 4'd1);
            end
          end else if (timer == TMAX) begin
            err   <= 1'b1;
            timer <= '0;
            addr  <= '0;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        DONE: if (bus.out_ready) err <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef AES_SHIFTROWS_EN
  // Row r rotates left by r columns: out(r,c) = st(r,(c+r) mod 4).
  always_comb begin
    cipher = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        cipher[8*(15 - (r + 4*c)) +: 8] = st[8*(15 - (r + 4*((c + r) % 4))) +: 8];
  end
`else
  assign cipher = st;
`endif

  assign bus.in_ready   = rdy;
  assign bus.sbox_req   = req;
  assign bus.sbox_addr  = addr;
  assign bus.out_valid  = vld;
  assign bus.out_cipher = cipher;
  assign bus.out_err    = err;
endmodule

// File: doc/aes_subbytes_engine.md
Name: aes_subbytes_engine

Overview:
- Parametrised AddRoundKey + SubBytes engine for the AES datapath.
- Captures a 128-bit word and round key, XORs them, then substitutes every state byte through the external S-box memory.
- The S-box memory is reached over a req/ack handshake that carries LANES bytes per beat.
- Results leave on a valid/ready output; a timeout flags an unresponsive memory.

Parameters:
- LANES, 4, bytes looked up per S-box beat; legal values are 1, 2, 4, 8, 16; BEATS = 16/LANES.
- TIMEOUT, 64, maximum cycles to wait for sbox_ack per beat; legal range 1..255.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word and key are valid.
- in_ready  out  1  engine idle and able to accept.
- in_word  in  128  plaintext/state; byte k = bits [127-8k -: 8], row k%4, column k/4.
- in_key  in  128  round key, same byte order as in_word.
- sbox_req  out  1  S-box lookup request, held until acknowledged.
- sbox_addr  out  8*LANES  lane j = state byte beat*LANES+j, at bits [8j+7:8j].
- sbox_ack  in  1  memory returns sbox_data for the current request.
- sbox_data  in  8*LANES  substituted bytes, same lane order as sbox_addr.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_cipher  out  128  result, same byte order as in_word.
- out_err  out  1  qualifies out_valid; set when a beat timed out.

Behaviour:
- Reset values: FSM=IDLE, in_ready=1, sbox_req=0, sbox_addr=0, out_valid=0, out_cipher=0, out_err=0, beat=0, timer=0.
- Reset is honoured in any state, including mid-lookup; any in-flight ack is dropped.
- IDLE: in_ready=1. When in_valid=1, load st <= in_word ^ in_key, set beat=0, timer=0, and go to REQ. in_ready is 0 in every other state.
- REQ: sbox_req=1 and sbox_addr = st bytes [beat*LANES .. beat*LANES+LANES-1], registered so the address is stable while req is high.
- REQ, sbox_ack=1: write sbox_data into those bytes and clear timer.
  - If beat=BEATS-1, go to DONE.
  - Otherwise beat++, stay in REQ, keep sbox_req high, and present the new address the next cycle.
- REQ, no ack: timer++. When timer reaches TIMEOUT-1 with no ack, set out_err=1, drop sbox_req, and go to DONE. The state is left partially substituted.
- sbox_ack is ignored whenever sbox_req=0; a stray ack has no effect.
- DONE: out_valid=1, with out_cipher=st (or the ShiftRows result, see Optional Feature). out_cipher and out_err stay stable until out_ready=1. On out_ready=1, clear out_valid and out_err and go to IDLE.
- A new input is accepted no earlier than the cycle after the handshake, because in_ready rises in IDLE. No back-to-back overlap.
- Latency with ack in the same cycle as req: accept at cycle 0, out_valid at cycle 1+BEATS. For LANES=4 that is cycle 5; for LANES=16 it is cycle 2.
- in_valid while busy is not accepted; the producer must hold the data until in_ready.
- All byte arithmetic is 8-bit XOR; there is no carry and no widening.

Optional Feature:
- Macro: AES_SHIFTROWS_EN.
- Defined: DONE output applies AES ShiftRows, out byte(r,c) = st(r,(c+r) mod 4), combinationally from st. Latency is unchanged.
- Undefined: out_cipher = st unchanged, i.e. SubBytes output only.
- out_err behaviour is identical in both builds.

Test Plan:
- LANES=4, 1-cycle-ack S-box model; word 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f:
  - Without the macro, out_cipher = 63cab7040953d051cd60e0e7ba70e18c, out_err=0, out_valid at cycle 5.
  - With AES_SHIFTROWS_EN, out_cipher = 6353e08c0960e104cd70b751bacad0e7.
- Sweep LANES=1, 2, 8, 16 with the same vector: identical result; exactly 16/LANES acks; sbox_addr lane order matches the byte index.
- Random ack delay of 0-10 cycles and TIMEOUT=64: result correct; sbox_addr stable while sbox_req=1; a stray ack injected in IDLE changes nothing.
- Memory never acks, TIMEOUT=8: sbox_req drops after 8 cycles of req in the beat; out_valid=1 with out_err=1; out_err clears after out_ready.
- out_ready held 0 for 20 cycles: out_valid and out_cipher stay stable and in_ready stays 0; the next word is accepted only after the handshake.
- rst pulsed during beat 2: next cycle sbox_req=0, in_ready=1, out_valid=0; a fresh vector then completes correctly.
